// File: rtl/uart_baud_ctrl.sv
// rtl/uart_baud_ctrl.sv - auto-baud detect/confirm controller driving uart_rx_byte Baud_sel
// Optional macro UART_BAUD_FORCE_EN adds the Force_en/Force_sel manual override.
module uart_baud_ctrl #(
    parameter int         CLK_FREQ    = 50_000_000,
    parameter logic [7:0] SYNC_BYTE   = 8'h55,
    parameter int         MAX_RETRY   = 4,
    parameter int         TIMEOUT_CYC = 2_000_000,
    parameter int         IDLE_CYC    = 5208
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       Uart_rx,
    input  logic       Relock,
    input  logic       Rx_done,
    input  logic [7:0] Rx_byte,
`ifdef UART_BAUD_FORCE_EN
    input  logic       Force_en,
    input  logic [2:0] Force_sel,
`endif
    output logic [2:0] Baud_sel,
    output logic       Baud_locked,
    output logic       Lock_err,
    output logic [2:0] Ctrl_state
);

    localparam int P9600   = CLK_FREQ / 9600;
    localparam int P19200  = CLK_FREQ / 19200;
    localparam int P38400  = CLK_FREQ / 38400;
    localparam int P57600  = CLK_FREQ / 57600;
    localparam int P115200 = CLK_FREQ / 115200;

    localparam logic [15:0] GLITCH_LIM = 16'(P115200 / 2);
    localparam logic [15:0] MID4       = 16'((P115200 + P57600) / 2);
    localparam logic [15:0] MID3       = 16'((P57600 + P38400) / 2);
    localparam logic [15:0] MID2       = 16'((P38400 + P19200) / 2);
    localparam logic [15:0] MID1       = 16'((P19200 + P9600) / 2);
    localparam logic [15:0] BREAK_LIM  = 16'(2 * P9600);

    localparam int HW = $clog2(IDLE_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam logic [HW-1:0] HI_TGT    = HW'(IDLE_CYC);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);
    localparam logic [RW-1:0] RETRY_TGT = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ARMED    = 3'd1,
        S_MEASURE  = 3'd2,
        S_CLASSIFY = 3'd3,
        S_CONFIRM  = 3'd4,
        S_LOCKED   = 3'd5,
        S_ERROR    = 3'd6
    } state_t;

    state_t          state, state_nxt;
    logic            rx_meta, rx_s, rx_d;
    logic [HW-1:0]   hi_cnt, hi_nxt;
    logic [15:0]     low_cnt, low_nxt;
    logic [TW-1:0]   tmo_cnt, tmo_nxt;
    logic [RW-1:0]   retry_cnt, retry_nxt;
    logic            first_seen, seen_nxt;
    logic [2:0]      sel_q, sel_nxt;
    logic            fall, rise, fail, restart;

    assign fall = rx_d & ~rx_s;
    assign rise = ~rx_d & rx_s;

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state      <= S_IDLE;
            rx_meta    <= 1'b1;
            rx_s       <= 1'b1;
            rx_d       <= 1'b1;
            hi_cnt     <= '0;
            low_cnt    <= '0;
            tmo_cnt    <= '0;
            retry_cnt  <= '0;
            first_seen <= 1'b0;
            sel_q      <= 3'd0;
        end else begin
            state      <= state_nxt;
            rx_meta    <= Uart_rx;
            rx_s       <= rx_meta;
            rx_d       <= rx_s;
            hi_cnt     <= hi_nxt;
            low_cnt    <= low_nxt;
            tmo_cnt    <= tmo_nxt;
            retry_cnt  <= retry_nxt;
            first_seen <= seen_nxt;
            sel_q      <= sel_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        hi_nxt    = hi_cnt;
        low_nxt   = low_cnt;
        tmo_nxt   = tmo_cnt;
        retry_nxt = retry_cnt;
        seen_nxt  = first_seen;
        sel_nxt   = sel_q;
        fail      = 1'b0;

        case (state)
            S_IDLE: begin
                if (hi_cnt == HI_TGT) begin
                    state_nxt = S_ARMED;
                    hi_nxt    = '0;
                end else if (rx_s) begin
                    hi_nxt = hi_cnt + HW'(1);
                end else begin
                    hi_nxt = '0;
                end
            end
            S_ARMED: begin
                if (fall) begin
                    state_nxt = S_MEASURE;
                    low_nxt   = 16'd1;
                end
            end
            S_MEASURE: begin
                // A start bit longer than two slowest bit times is a break, not a sync byte
                if (low_cnt > BREAK_LIM) begin
                    state_nxt = S_IDLE;
                    low_nxt   = '0;
                end else if (rise) begin
                    state_nxt = S_CLASSIFY;
                end else if (!rx_s && low_cnt != 16'hFFFF) begin
                    low_nxt = low_cnt + 16'd1;
                end
            end
            S_CLASSIFY: begin
                low_nxt = '0;
                if (low_cnt < GLITCH_LIM) begin
                    state_nxt = S_ARMED;
                end else begin
                    state_nxt = S_CONFIRM;
                    tmo_nxt   = '0;
                    seen_nxt  = 1'b0;
                    if (low_cnt < MID4)      sel_nxt = 3'd4;
                    else if (low_cnt < MID3) sel_nxt = 3'd3;
                    else if (low_cnt < MID2) sel_nxt = 3'd2;
                    else if (low_cnt < MID1) sel_nxt = 3'd1;
                    else                     sel_nxt = 3'd0;
                end
            end
            S_CONFIRM: begin
                tmo_nxt = tmo_cnt + TW'(1);
                // The first byte is the one we measured; only the second one proves the rate
                if (Rx_done) begin
                    if (!first_seen) begin
                        seen_nxt = 1'b1;
                    end else if (Rx_byte == SYNC_BYTE) begin
                        state_nxt = S_LOCKED;
                        retry_nxt = '0;
                    end else begin
                        fail = 1'b1;
                    end
                end else if (tmo_cnt == TMO_LAST) begin
                    fail = 1'b1;
                end
                if (fail) begin
                    retry_nxt = retry_cnt + RW'(1);
                    state_nxt = (retry_cnt + RW'(1) == RETRY_TGT) ? S_ERROR : S_IDLE;
                end
                if (state_nxt != S_CONFIRM) begin
                    tmo_nxt  = '0;
                    seen_nxt = 1'b0;
                end
            end
            S_LOCKED: state_nxt = S_LOCKED;
            S_ERROR:  state_nxt = S_ERROR;
            default:  state_nxt = S_IDLE;
        endcase

`ifdef UART_BAUD_FORCE_EN
        restart = Relock | Force_en;
        if (Force_en) sel_nxt = Force_sel;
`else
        restart = Relock;
`endif
        if (restart) begin
            state_nxt = S_IDLE;
            hi_nxt    = '0;
            low_nxt   = '0;
            tmo_nxt   = '0;
            retry_nxt = '0;
            seen_nxt  = 1'b0;
        end
    end

    assign Ctrl_state = state;
    assign Lock_err   = (state == S_ERROR);
`ifdef UART_BAUD_FORCE_EN
    assign Baud_sel    = Force_en ? Force_sel : sel_q;
    assign Baud_locked = Force_en | (state == S_LOCKED);
`else
    assign Baud_sel    = sel_q;
    assign Baud_locked = (state == S_LOCKED);
`endif

endmodule
